// File: rtl/clk_div_pkg.sv
// Shared constants for the stopwatch timing front end: clock rate,
// the default debounce length and the fixed divider counter widths.
package clk_div_pkg;

  localparam int CLK_HZ        = 100_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;

  localparam int W1   = 27;
  localparam int W2   = 26;
  localparam int W7   = 18;
  localparam int WADJ = 26;

  // Width needed to count 0..modulus-1, never narrower than one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: two-flop synchronizer followed by a stability
// counter. The output follows only after DB_CYCLES consecutive differing samples.
module btn_debounce
  import clk_div_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int            CW   = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: every flop is reset here, synchronizer stages included, so the
  // level pressed before reset must be re-qualified from scratch afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync1 -> sync2 a true two-stage shift.
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div.sv
// Stopwatch timing front end: four free-running divider counters whose zero
// value marks a tick, plus two debounced push-button levels.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int DIV_1HZ   = CLK_HZ,
  parameter int DIV_2HZ   = CLK_HZ / 2,
  parameter int DIV_ADJ   = CLK_HZ / 5,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int SCAN_W    = W7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_right,
  input  logic              btn_center,
  output logic [W1-1:0]     out1,
  output logic [W2-1:0]     out2,
  output logic [SCAN_W-1:0] out7seg,
  output logic [WADJ-1:0]   outadj,
  output logic              btn_reset,
  output logic              btn_set_pause
);

  localparam logic [W1-1:0]   LAST_1HZ = W1'(DIV_1HZ - 1);
  localparam logic [W2-1:0]   LAST_2HZ = W2'(DIV_2HZ - 1);
  localparam logic [WADJ-1:0] LAST_ADJ = WADJ'(DIV_ADJ - 1);

  // Same modulo-N pattern for every divider; the scan counter wraps at its width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out1    <= '0;
      out2    <= '0;
      out7seg <= '0;
      outadj  <= '0;
    end else begin
      out1    <= (out1   == LAST_1HZ) ? '0 : out1   + W1'(1);
      out2    <= (out2   == LAST_2HZ) ? '0 : out2   + W2'(1);
      outadj  <= (outadj == LAST_ADJ) ? '0 : outadj + WADJ'(1);
      out7seg <= out7seg + SCAN_W'(1);
    end
  end

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_reset (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_right),
    .dout (btn_reset)
  );

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db_set_pause (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_center),
    .dout (btn_set_pause)
  );

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div with small divider/debounce overrides,
// directed scenarios plus randomized button traffic against a reference model.
module tb_clk_div;

  localparam int D1     = 10;
  localparam int D2     = 5;
  localparam int DADJ   = 2;
  localparam int DB     = 4;
  localparam int SCAN_W = 12;
  localparam int NE     = 20000;

  logic              clk = 1'b0;
  logic              rst;
  logic              btn_right;
  logic              btn_center;
  logic [26:0]       out1;
  logic [25:0]       out2;
  logic [SCAN_W-1:0] out7seg;
  logic [25:0]       outadj;
  logic              btn_reset;
  logic              btn_set_pause;

  clk_div #(
    .DIV_1HZ   (D1),
    .DIV_2HZ   (D2),
    .DIV_ADJ   (DADJ),
    .DB_CYCLES (DB),
    .SCAN_W    (SCAN_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_right     (btn_right),
    .btn_center    (btn_center),
    .out1          (out1),
    .out2          (out2),
    .out7seg       (out7seg),
    .outadj        (outadj),
    .btn_reset     (btn_reset),
    .btn_set_pause (btn_set_pause)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: counters are the number of clock edges since release
  // reduced modulo each divider; a debounced level flips once the raw input,
  // seen two edges late, has held the opposite value for DB edges since the
  // last flip or release.
  int kcnt   = 0;      // edges since reset release
  int e      = 0;      // absolute edge index
  int rel    = 0;      // edge index of first edge after release
  int lf_r, lf_c;      // edge index of last flip per channel
  bit m_reset, m_sp;
  bit raw_r [NE];
  bit raw_c [NE];

  function automatic bit raw_at(input bit ch, input int m);
    if (m < rel) return 1'b0;
    return ch ? raw_c[m] : raw_r[m];
  endfunction

  function automatic bit held_for_db(input bit ch, input int n, input bit v);
    for (int j = 2; j < DB + 2; j++)
      if (raw_at(ch, n - j) != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    if (e >= NE) begin
      $display("FAIL model_edge: history overflow at edge %0d", e);
      $fatal(1);
    end
    raw_r[e] = btn_right;
    raw_c[e] = btn_center;
    if (e - lf_r >= DB && held_for_db(1'b0, e, !m_reset)) begin
      m_reset = !m_reset;
      lf_r    = e;
    end
    if (e - lf_c >= DB && held_for_db(1'b1, e, !m_sp)) begin
      m_sp = !m_sp;
      lf_c = e;
    end
    kcnt++;
    e++;
  endtask

  task automatic model_reset();
    kcnt    = 0;
    m_reset = 1'b0;
    m_sp    = 1'b0;
  endtask

  task automatic model_release();
    rel  = e;
    lf_r = e - 1;
    lf_c = e - 1;
    kcnt = 0;
  endtask

  task automatic compare_all();
    check("out1",          32'(out1),          32'(kcnt % D1));
    check("out2",          32'(out2),          32'(kcnt % D2));
    check("outadj",        32'(outadj),        32'(kcnt % DADJ));
    check("out7seg",       32'(out7seg),       32'(kcnt % (1 << SCAN_W)));
    check("btn_reset",     32'(btn_reset),     32'(m_reset));
    check("btn_set_pause", 32'(btn_set_pause), 32'(m_sp));
  endtask

  // One clock cycle: model advances on the edge, outputs compared at negedge.
  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int last_z1, last_z2;

    rst        = 1'b0;
    btn_right  = 1'b0;
    btn_center = 1'b0;
    model_reset();
    repeat (3) step();

    // Reset release: zero until the first edge, then one.
    rst = 1'b1;
    model_release();
    #1;
    check("rel_out1_0",    32'(out1),    0);
    check("rel_out2_0",    32'(out2),    0);
    check("rel_outadj_0",  32'(outadj),  0);
    check("rel_out7seg_0", 32'(out7seg), 0);
    step();
    check("rel_out1_1",    32'(out1),    1);
    check("rel_out2_1",    32'(out2),    1);
    check("rel_outadj_1",  32'(outadj),  1);
    check("rel_out7seg_1", 32'(out7seg), 1);

    // Wrap spacing of tick zeros.
    last_z1 = -1;
    last_z2 = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out1 == 0) begin
        if (last_z1 >= 0) check("out1_zero_gap", 32'(i - last_z1), D1);
        last_z1 = i;
      end
      if (out2 == 0) begin
        if (last_z2 >= 0) check("out2_zero_gap", 32'(i - last_z2), D2);
        last_z2 = i;
      end
    end

    // Clean press and release on btn_right.
    btn_right = 1'b1;
    repeat (DB + 1) step();
    check("press_not_yet", 32'(btn_reset), 0);
    step();
    check("press_rise", 32'(btn_reset), 1);
    repeat (4) step();
    btn_right = 1'b0;
    repeat (DB + 1) step();
    check("release_not_yet", 32'(btn_reset), 1);
    step();
    check("release_fall", 32'(btn_reset), 0);

    // Bouncy press on btn_center.
    btn_center = 1'b1;
    repeat (3) step();
    check("bounce_hold_a", 32'(btn_set_pause), 0);
    btn_center = 1'b0;
    step();
    check("bounce_gap", 32'(btn_set_pause), 0);
    btn_center = 1'b1;
    repeat (DB + 1) step();
    check("bounce_not_yet", 32'(btn_set_pause), 0);
    step();
    check("bounce_rise", 32'(btn_set_pause), 1);
    btn_center = 1'b0;
    repeat (8) step();

    // Asynchronous reset in the middle of a count with btn_reset high.
    btn_right = 1'b1;
    repeat (DB + 3) step();
    check("hold_before_rst", 32'(btn_reset), 1);
    for (int i = 0; i < 3 * D1 && out1 != 7; i++) step();
    check("wait_out1_7", 32'(out1), 7);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_out1",      32'(out1),      0);
    check("arst_out2",      32'(out2),      0);
    check("arst_outadj",    32'(outadj),    0);
    check("arst_out7seg",   32'(out7seg),   0);
    check("arst_btn_reset", 32'(btn_reset), 0);
    repeat (2) step();
    rst = 1'b1;
    model_release();
    repeat (DB + 1) step();
    check("rerise_not_yet", 32'(btn_reset), 0);
    step();
    check("rerise", 32'(btn_reset), 1);

    // Randomized button traffic, checked every cycle by the model.
    for (int i = 0; i < 80; i++) begin
      btn_right  = 1'($urandom % 2);
      btn_center = 1'($urandom % 2);
      repeat ($urandom_range(1, 2 * DB + 1)) step();
    end
    btn_right  = 1'b0;
    btn_center = 1'b0;

    // Scan counter natural wrap.
    for (int i = 0; i < (1 << SCAN_W) + 10 && out7seg != (1 << SCAN_W) - 1; i++) step();
    check("scan_top", 32'(out7seg), (1 << SCAN_W) - 1);
    step();
    check("scan_wrap", 32'(out7seg), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
